// File: rtl/mpsoc_boot_pkg.sv
// mpsoc_boot_pkg: shared state/command encodings and timer sizing for the boot sequencer.
package mpsoc_boot_pkg;

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_STAGGER = 3'd2,
        ST_RUN     = 3'd3,
        ST_HALTED  = 3'd4
    } boot_state_t;

    typedef enum logic [1:0] {
        CMD_RUN   = 2'd0,
        CMD_HALT  = 2'd1,
        CMD_RESET = 2'd2,
        CMD_RSVD  = 2'd3
    } host_cmd_t;

    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mpsoc_boot_timer.sv
// mpsoc_boot_timer: loadable down-counter that saturates at zero.
//   clk       system clock
//   load      load load_val this cycle (takes priority over counting)
//   load_val  value to load
//   value     current count
//   zero      high while value is zero
module mpsoc_boot_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         zero
);

    assign zero = (value == '0);

    always_ff @(posedge clk) begin
        if (load)
            value <= load_val;
        else if (!zero)
            value <= value - 1'b1;
    end

endmodule

// File: rtl/mpsoc_boot_ctrl.sv
// mpsoc_boot_ctrl: boot/run sequencer driving reset and staggered tile enables of mor1k_mpsoc.
//   clk             system clock
//   reset           synchronous active-low reset
//   host_req_valid  host command valid
//   host_req_cmd    0=RUN 1=HALT 2=RESET 3=reserved
//   host_req_ready  command accepted on valid&ready
//   cpu_heartbeat   per-tile watchdog kick
//   soc_reset       active-high SoC reset
//   processors_en   per-tile enables
//   boot_done       high while running
//   wdt_bite        one-cycle watchdog expiry pulse
//   state_o         current state (debug)
// Optional watchdog enabled by defining MPSOC_BOOT_WDT_EN.
module mpsoc_boot_ctrl
    import mpsoc_boot_pkg::*;
#(
    parameter int NT           = 4,
    parameter int RST_HOLD_CYC = 20,
    parameter int SETTLE_CYC   = 4,
    parameter int STAGGER_CYC  = 2,
    parameter int WDT_CYC      = 65536
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          host_req_valid,
    input  logic [1:0]    host_req_cmd,
    output logic          host_req_ready,
    input  logic [NT-1:0] cpu_heartbeat,
    output logic          soc_reset,
    output logic [NT-1:0] processors_en,
    output logic          boot_done,
    output logic          wdt_bite,
    output logic [2:0]    state_o
);

    localparam int TW = timer_width(RST_HOLD_CYC, SETTLE_CYC, STAGGER_CYC);
    localparam logic [TW-1:0] HOLD_LD   = TW'(RST_HOLD_CYC - 1);
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] STAG_LD   = TW'(STAGGER_CYC - 1);

    boot_state_t   state, nxt;
    host_cmd_t     cmd;
    logic [NT-1:0] en_nxt;
    logic          accept, tmr_load, tmr_zero, bite_nxt, wdt_expire;
    logic [TW-1:0] tmr_val, unused_tmr_value;

    assign cmd     = host_cmd_t'(host_req_cmd);
    assign accept  = host_req_valid & host_req_ready;
    assign state_o = state;

    mpsoc_boot_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (unused_tmr_value),
        .zero     (tmr_zero)
    );

`ifdef MPSOC_BOOT_WDT_EN
    localparam int WW = $clog2(WDT_CYC);
    logic [WW-1:0] wdt;
    // A kick in the same cycle as expiry wins; accepted host commands are resolved before this.
    assign wdt_expire = (state == ST_RUN) && !(|cpu_heartbeat) && (wdt == '0);
    always_ff @(posedge clk) begin
        if (!reset)
            wdt <= WW'(WDT_CYC - 1);
        else if (nxt == ST_RUN && (state != ST_RUN || |cpu_heartbeat))
            wdt <= WW'(WDT_CYC - 1);
        else if (state == ST_RUN && nxt == ST_RUN)
            wdt <= wdt - 1'b1;
    end
`else
    logic unused_wdt;
    assign wdt_expire = 1'b0;
    assign unused_wdt = ^{cpu_heartbeat, WDT_CYC != 0};
`endif

    always_comb begin
        nxt      = state;
        en_nxt   = processors_en;
        tmr_load = 1'b0;
        tmr_val  = HOLD_LD;
        bite_nxt = 1'b0;
        case (state)
            ST_HOLD: begin
                if (tmr_zero) begin
                    nxt      = ST_SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                end
            end
            ST_SETTLE: nxt = tmr_zero ? ST_STAGGER : ST_SETTLE;
            ST_STAGGER: begin
                if (&processors_en)
                    nxt = ST_RUN;
                else if (tmr_zero) begin
                    en_nxt   = (processors_en << 1) | NT'(1);
                    tmr_load = 1'b1;
                    tmr_val  = STAG_LD;
                end
            end
            ST_RUN: begin
                if (accept && cmd == CMD_HALT)
                    nxt = ST_HALTED;
                else if (accept && cmd == CMD_RESET)
                    nxt = ST_HOLD;
                else if (wdt_expire) begin
                    nxt      = ST_HOLD;
                    bite_nxt = 1'b1;
                end
            end
            ST_HALTED: begin
                if (accept && cmd == CMD_RUN)
                    nxt = ST_STAGGER;
                else if (accept && cmd == CMD_RESET)
                    nxt = ST_HOLD;
            end
            default: nxt = ST_HOLD;
        endcase
        // Phase-entry actions shared by every path into a state.
        if (nxt == ST_HOLD && state != ST_HOLD) begin
            tmr_load = 1'b1;
            tmr_val  = HOLD_LD;
            en_nxt   = '0;
        end
        if (nxt == ST_STAGGER && state != ST_STAGGER) begin
            tmr_load = 1'b1;
            tmr_val  = STAG_LD;
            en_nxt   = NT'(1);
        end
        if (nxt == ST_HALTED)
            en_nxt = '0;
        if (!reset) begin
            tmr_load = 1'b1;
            tmr_val  = HOLD_LD;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= ST_HOLD;
            processors_en  <= '0;
            soc_reset      <= 1'b1;
            boot_done      <= 1'b0;
            host_req_ready <= 1'b0;
            wdt_bite       <= 1'b0;
        end else begin
            state          <= nxt;
            processors_en  <= en_nxt;
            soc_reset      <= (nxt == ST_HOLD);
            boot_done      <= (nxt == ST_RUN);
            host_req_ready <= (nxt == ST_RUN) || (nxt == ST_HALTED);
            wdt_bite       <= bite_nxt;
        end
    end

endmodule

// File: tb/tb_mpsoc_boot_ctrl.sv
// tb_mpsoc_boot_ctrl: randomized and directed checks of mpsoc_boot_ctrl against a phase/age model.
module tb_mpsoc_boot_ctrl;

    localparam int NT = 4, RH = 20, SC = 4, SG = 2, WC = 100;
    localparam int P_HOLD = 0, P_SETTLE = 1, P_STAGGER = 2, P_RUN = 3, P_HALTED = 4;
    localparam logic [1:0] C_RUN = 2'd0, C_HALT = 2'd1, C_RESET = 2'd2, C_RSVD = 2'd3;

    logic          clk = 1'b0, reset = 1'b0, host_req_valid = 1'b0;
    logic [1:0]    host_req_cmd = 2'd0;
    logic [NT-1:0] cpu_heartbeat = '0;
    logic          host_req_ready, soc_reset, boot_done, wdt_bite;
    logic [NT-1:0] processors_en;
    logic [2:0]    state_o;

    int   vecs = 0, errs = 0;
    int   ph = P_HOLD, age = 0, wage = 0;
    logic m_bite = 1'b0, accepted = 1'b0;

    wire [NT+6:0] obs = {soc_reset, processors_en, boot_done, host_req_ready, wdt_bite, state_o};

    always #5 clk = ~clk;

    mpsoc_boot_ctrl #(
        .NT(NT), .RST_HOLD_CYC(RH), .SETTLE_CYC(SC), .STAGGER_CYC(SG), .WDT_CYC(WC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .host_req_valid (host_req_valid),
        .host_req_cmd   (host_req_cmd),
        .host_req_ready (host_req_ready),
        .cpu_heartbeat  (cpu_heartbeat),
        .soc_reset      (soc_reset),
        .processors_en  (processors_en),
        .boot_done      (boot_done),
        .wdt_bite       (wdt_bite),
        .state_o        (state_o)
    );

    // Expected outputs from phase and cycles spent in it: stagger shows one more tile per SG cycles.
    function automatic logic [NT+6:0] expv();
        logic [NT-1:0] en = '0;
        int k = 0;
        if (ph == P_RUN) k = NT;
        else if (ph == P_STAGGER) k = (age / SG + 1 > NT) ? NT : age / SG + 1;
        for (int i = 0; i < NT; i++) en[i] = (i < k);
        return {ph == P_HOLD, en, ph == P_RUN, ph == P_RUN || ph == P_HALTED, m_bite, 3'(ph)};
    endfunction

    task automatic step();
        @(posedge clk);
        accepted = 1'b0;
        m_bite   = 1'b0;
        if (!reset) begin
            ph = P_HOLD; age = 0;
        end else case (ph)
            P_HOLD:    if (age == RH - 1) begin ph = P_SETTLE; age = 0; end else age++;
            P_SETTLE:  if (age == SC - 1) begin ph = P_STAGGER; age = 0; end else age++;
            P_STAGGER: if (age == (NT - 1) * SG) begin ph = P_RUN; wage = 0; end else age++;
            P_RUN: begin
                accepted = host_req_valid;
                if (accepted && host_req_cmd == C_HALT) ph = P_HALTED;
                else if (accepted && host_req_cmd == C_RESET) begin ph = P_HOLD; age = 0; end
`ifdef MPSOC_BOOT_WDT_EN
                else if (cpu_heartbeat != '0) wage = 0;
                else if (wage == WC - 1) begin m_bite = 1'b1; ph = P_HOLD; age = 0; end
                else wage++;
`endif
            end
            P_HALTED: begin
                accepted = host_req_valid;
                if (accepted && host_req_cmd == C_RUN) begin ph = P_STAGGER; age = 0; end
                else if (accepted && host_req_cmd == C_RESET) begin ph = P_HOLD; age = 0; end
            end
            default: ;
        endcase
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); vecs++;
            if (obs !== expv()) begin $display("FAIL reset_cyc%0d: got %b exp %b", i, obs, expv()); errs++; end
        end
        vecs++;
        if (obs !== {1'b1, {NT{1'b0}}, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            $display("FAIL reset_values: got %b exp %b", obs, {1'b1, {NT{1'b0}}, 5'b00000}); errs++;
        end
        reset = 1'b1;
    endtask

    task automatic test_boot();
        int hi = 1, done_at = 0;
        for (int i = 1; i <= 60 && done_at == 0; i++) begin
            step(); vecs++;
            if (obs !== expv()) begin $display("FAIL boot_cyc%0d: got %b exp %b", i, obs, expv()); errs++; end
            if (soc_reset === 1'b1) hi++;
            if (boot_done === 1'b1) done_at = i;
        end
        vecs++;
        if (hi != RH) begin $display("FAIL boot_hold_len: got %0d exp %0d", hi, RH); errs++; end
        vecs++;
        if (done_at != RH + SC + (NT - 1) * SG + 1) begin
            $display("FAIL boot_done_time: got %0d exp %0d", done_at, RH + SC + (NT - 1) * SG + 1); errs++;
        end
    endtask

    task automatic test_halt_run();
        logic [1:0] seq [4] = '{C_HALT, C_HALT, C_RSVD, C_RUN};
        for (int s = 0; s < 4; s++) begin
            host_req_valid = 1'b1; host_req_cmd = seq[s];
            step(); vecs++;
            if (obs !== expv()) begin $display("FAIL halt_run_cmd%0d: got %b exp %b", s, obs, expv()); errs++; end
            host_req_valid = 1'b0;
            if (s == 0) begin
                vecs++;
                if (processors_en !== '0 || soc_reset !== 1'b0 || boot_done !== 1'b0) begin
                    $display("FAIL halt_outputs: got en=%b rst=%b done=%b exp 0000/0/0", processors_en, soc_reset, boot_done); errs++;
                end
            end
            if (s == 3) begin
                vecs++;
                if (processors_en !== NT'(1)) begin $display("FAIL restart_en: got %b exp 0001", processors_en); errs++; end
            end
            for (int i = 0; i < 3 && s < 3; i++) begin
                step(); vecs++;
                if (obs !== expv()) begin $display("FAIL halt_idle%0d: got %b exp %b", s, obs, expv()); errs++; end
            end
        end
        for (int i = 0; i < 40 && ph != P_RUN; i++) begin
            step(); vecs++;
            if (obs !== expv()) begin $display("FAIL restagger: got %b exp %b", obs, expv()); errs++; end
        end
    endtask

    task automatic test_reset_cmd();
        int hi = 0;
        host_req_valid = 1'b1; host_req_cmd = C_RESET;
        step(); vecs++;
        if (obs !== expv()) begin $display("FAIL reset_cmd_accept: got %b exp %b", obs, expv()); errs++; end
        host_req_valid = 1'b0;
        if (soc_reset === 1'b1) hi++;
        for (int i = 0; i < 80 && ph != P_RUN; i++) begin
            step(); vecs++;
            if (obs !== expv()) begin $display("FAIL reset_cmd_boot: got %b exp %b", obs, expv()); errs++; end
            if (soc_reset === 1'b1) hi++;
        end
        vecs++;
        if (hi != RH) begin $display("FAIL reset_cmd_hold_len: got %0d exp %0d", hi, RH); errs++; end
    endtask

    task automatic test_early_cmd();
        reset = 1'b0; host_req_valid = 1'b1; host_req_cmd = C_HALT;
        step(); reset = 1'b1;
        for (int i = 0; i < 80 && !accepted; i++) begin
            step(); vecs++;
            if (obs !== expv()) begin $display("FAIL early_cmd: got %b exp %b", obs, expv()); errs++; end
        end
        host_req_valid = 1'b0;
        vecs++;
        if (state_o !== 3'd4 || host_req_ready !== 1'b1) begin
            $display("FAIL early_cmd_halted: got state=%0d rdy=%b exp 4/1", state_o, host_req_ready); errs++;
        end
    endtask

    task automatic test_mid_stagger();
        reset = 1'b0; step(); reset = 1'b1;
        for (int i = 0; i < 60 && !(ph == P_STAGGER && age == SG); i++) begin
            step(); vecs++;
            if (obs !== expv()) begin $display("FAIL mid_stagger_boot: got %b exp %b", obs, expv()); errs++; end
        end
        vecs++;
        if (processors_en !== NT'(3)) begin $display("FAIL mid_stagger_en: got %b exp 0011", processors_en); errs++; end
        reset = 1'b0;
        step(); vecs++;
        if (obs !== {1'b1, {NT{1'b0}}, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            $display("FAIL mid_stagger_reset: got %b exp %b", obs, {1'b1, {NT{1'b0}}, 5'b00000}); errs++;
        end
        reset = 1'b1;
        for (int i = 0; i < 60 && ph != P_RUN; i++) begin
            step(); vecs++;
            if (obs !== expv()) begin $display("FAIL mid_stagger_reboot: got %b exp %b", obs, expv()); errs++; end
        end
    endtask

    task automatic test_wdt();
        int run_cyc = 0, bites = 0;
`ifdef MPSOC_BOOT_WDT_EN
        for (int i = 1; i <= 150 && bites == 0; i++) begin
            step(); vecs++;
            if (obs !== expv()) begin $display("FAIL wdt_starve: got %b exp %b", obs, expv()); errs++; end
            if (wdt_bite === 1'b1) begin bites++; run_cyc = i; end
        end
        vecs++;
        if (run_cyc != WC || state_o !== 3'd0) begin
            $display("FAIL wdt_bite_time: got %0d state=%0d exp %0d state=0", run_cyc, state_o, WC); errs++;
        end
        step(); vecs++;
        if (wdt_bite !== 1'b0) begin $display("FAIL wdt_pulse_width: got %b exp 0", wdt_bite); errs++; end
        for (int i = 0; i < 80 && ph != P_RUN; i++) step();
        bites = 0;
        for (int i = 1; i <= 300; i++) begin
            cpu_heartbeat = (i % 50 == 0) ? NT'(1 << (i % NT)) : '0;
            step(); vecs++;
            if (obs !== expv()) begin $display("FAIL wdt_kicked: got %b exp %b", obs, expv()); errs++; end
            if (wdt_bite === 1'b1) bites++;
        end
`else
        for (int i = 1; i <= 300; i++) begin
            cpu_heartbeat = (i < 150) ? NT'($urandom) : '0;
            step(); vecs++;
            if (obs !== expv()) begin $display("FAIL wdt_absent: got %b exp %b", obs, expv()); errs++; end
            if (wdt_bite === 1'b1) bites++;
        end
`endif
        cpu_heartbeat = '0;
        vecs++;
        if (bites != 0 || state_o !== 3'd3) begin
            $display("FAIL wdt_no_bite: got bites=%0d state=%0d exp 0/3", bites, state_o); errs++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            step(); vecs++;
            if (obs !== expv()) begin $display("FAIL random_cyc%0d: got %b exp %b", i, obs, expv()); errs++; end
            if (accepted) host_req_valid = 1'b0;
            if (!host_req_valid && $urandom_range(0, 9) == 0) begin
                host_req_valid = 1'b1;
                host_req_cmd   = 2'($urandom);
            end
            cpu_heartbeat = ($urandom_range(0, 59) == 0) ? NT'($urandom) : '0;
            reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
        end
        reset = 1'b1; host_req_valid = 1'b0; cpu_heartbeat = '0;
    endtask

    initial begin
        test_reset();
        test_boot();
        test_halt_run();
        test_reset_cmd();
        test_early_cmd();
        test_mid_stagger();
        test_wdt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
